// File: rtl/convolutional_encoder.sv
// -----------------------------------------------------------------------------
// convolutional_encoder
//
// Table-driven convolutional encoder, the transmit-side partner of the
// table-driven Viterbi decoder. It uses the same Next State / Output tables and
// the same load interface. A k*L-bit message frame is latched on start. One
// n-bit encoded slice is emitted per enabled cycle for L steps, and the full
// n*L-bit frame is assembled alongside.
//
// Ports
//   clk             : system clock, rising edge
//   reset_n         : asynchronous active-low reset (clears tables and outputs)
//   restart         : synchronous abandon-frame, back to IDLE, tables retained
//   enable          : step qualifier, 0 pauses encoding
//   start           : frame start request, honoured in IDLE only
//   message         : [0:K*L-1] frame, slice j = message[K*j +: K]
//   load            : table write strobe (accepted in IDLE only)
//   state_address   : table row
//   input_address   : table column
//   next_state_data : Next State Table write data
//   output_data     : [0:N-1] Output Table write data
//   encoded         : [0:N-1] current encoded slice
//   encoded_valid   : one-cycle pulse per emitted slice
//   encoded_frame   : [0:N*L-1] accumulated frame, slice j at [N*j +: N]
//   final_state     : encoder state after the last step
//   busy            : high while in RUN
//   done            : high while in DONE
// -----------------------------------------------------------------------------
module convolutional_encoder #(
    parameter int N = 2,
    parameter int K = 1,
    parameter int M = 4,
    parameter int L = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               restart,
    input  logic               enable,
    input  logic               start,
    input  logic [0:K*L-1]     message,
    input  logic               load,
    input  logic [M-K-1:0]     state_address,
    input  logic [K-1:0]       input_address,
    input  logic [M-K-1:0]     next_state_data,
    input  logic [0:N-1]       output_data,
    output logic [0:N-1]       encoded,
    output logic               encoded_valid,
    output logic [0:N*L-1]     encoded_frame,
    output logic [M-K-1:0]     final_state,
    output logic               busy,
    output logic               done
);

    localparam int S     = M - K;          // state register width
    localparam int DEPTH = 1 << M;         // 2^(m-k) rows x 2^k columns
    localparam int CW    = $clog2(L) + 1;  // step counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } fsm_t;

    // Tables, flattened so that row/column concatenate into one index.
    logic [S-1:0]   ns_table_r  [0:DEPTH-1];
    logic [0:N-1]   out_table_r [0:DEPTH-1];

    // Registered state
    fsm_t           fsm_r;
    logic [CW-1:0]  cnt_r;
    logic [0:K*L-1] msg_r;
    logic [S-1:0]   enc_state_r;
    logic [0:N-1]   encoded_r;
    logic           valid_r;
    logic [0:N*L-1] frame_r;
    logic [S-1:0]   final_r;
    logic           busy_r;
    logic           done_r;

    // Next-state values
    fsm_t           fsm_s;
    logic [CW-1:0]  cnt_s;
    logic [0:K*L-1] msg_s;
    logic [S-1:0]   enc_state_s;
    logic [0:N-1]   encoded_s;
    logic           valid_s;
    logic [0:N*L-1] frame_s;
    logic [S-1:0]   final_s;
    logic           busy_s;
    logic           done_s;

    // Datapath helpers
    logic           wr_en_s;
    logic [M-1:0]   wr_idx_s;
    logic [K-1:0]   u_s;
    logic [M-1:0]   rd_idx_s;
    logic [0:N-1]   out_s;
    logic [S-1:0]   ns_s;
    logic [0:N*L-1] frame_step_s;

    // Writes are only honoured in IDLE so a running frame never sees a table change.
    always_comb begin
        wr_en_s  = load && (fsm_r == ST_IDLE);
        wr_idx_s = {state_address, input_address};
    end

    // Table storage: cleared by reset_n, written from the load port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ns_table_r[i]  <= '0;
                out_table_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            ns_table_r[wr_idx_s]  <= next_state_data;
            out_table_r[wr_idx_s] <= output_data;
        end
    end

    // Select the message symbol for the current step by one-hot masking on the counter.
    always_comb begin
        u_s = '0;
        for (int j = 0; j < L; j++) begin
            u_s = u_s | (msg_r[K*j +: K] & {K{cnt_r == CW'(j)}});
        end
    end

    // Table lookup for the current (state, symbol) pair.
    always_comb begin
        rd_idx_s = {enc_state_r, u_s};
        out_s    = out_table_r[rd_idx_s];
        ns_s     = ns_table_r[rd_idx_s];
    end

    // Frame image with the current slice dropped into its slot.
    always_comb begin
        frame_step_s = frame_r;
        for (int j = 0; j < L; j++) begin
            frame_step_s[N*j +: N] = (cnt_r == CW'(j)) ? out_s : frame_r[N*j +: N];
        end
    end

    // FSM next-state and datapath next values; restart overrides everything else.
    always_comb begin
        fsm_s       = fsm_r;
        cnt_s       = cnt_r;
        msg_s       = msg_r;
        enc_state_s = enc_state_r;
        encoded_s   = encoded_r;
        valid_s     = 1'b0;
        frame_s     = frame_r;
        final_s     = final_r;

        if (restart) begin
            fsm_s       = ST_IDLE;
            cnt_s       = '0;
            enc_state_s = '0;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    // A simultaneous load takes precedence over start.
                    if (start && enable && !load) begin
                        fsm_s       = ST_RUN;
                        msg_s       = message;
                        enc_state_s = '0;
                        cnt_s       = '0;
                        frame_s     = '0;
                    end else begin
                        fsm_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (enable) begin
                        encoded_s   = out_s;
                        frame_s     = frame_step_s;
                        enc_state_s = ns_s;
                        valid_s     = 1'b1;
                        cnt_s       = cnt_r + CW'(1);
                        if (cnt_r == CW'(L - 1)) begin
                            fsm_s   = ST_DONE;
                            final_s = ns_s;
                        end else begin
                            fsm_s = ST_RUN;
                        end
                    end else begin
                        // Pause: everything holds, valid drops via the default.
                        fsm_s = ST_RUN;
                    end
                end
                ST_DONE: begin
                    fsm_s = ST_DONE;
                end
                default: begin
                    fsm_s       = ST_IDLE;
                    cnt_s       = '0;
                    enc_state_s = '0;
                end
            endcase
        end

        busy_s = (fsm_s == ST_RUN);
        done_s = (fsm_s == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_r       <= ST_IDLE;
            cnt_r       <= '0;
            msg_r       <= '0;
            enc_state_r <= '0;
            encoded_r   <= '0;
            valid_r     <= 1'b0;
            frame_r     <= '0;
            final_r     <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            fsm_r       <= fsm_s;
            cnt_r       <= cnt_s;
            msg_r       <= msg_s;
            enc_state_r <= enc_state_s;
            encoded_r   <= encoded_s;
            valid_r     <= valid_s;
            frame_r     <= frame_s;
            final_r     <= final_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign encoded       = encoded_r;
    assign encoded_valid = valid_r;
    assign encoded_frame = frame_r;
    assign final_state   = final_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_convolutional_encoder.sv
// -----------------------------------------------------------------------------
// tb_convolutional_encoder
//
// Directed bench for convolutional_encoder with the rate-1/2, m=4 code
// (generators 1111 / 1101). Tables are written from the generator definition.
// Expected slices and frames are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_convolutional_encoder;

    localparam int N = 2;
    localparam int K = 1;
    localparam int M = 4;
    localparam int L = 7;

    localparam logic [0:6]  MSG_A   = 7'b1011000;
    localparam logic [0:6]  MSG_B   = 7'b1000000;
    localparam logic [0:6]  MSG_Z   = 7'b0000000;
    localparam logic [0:13] FRAME_A = 14'b11_11_01_11_01_01_11;
    localparam logic [0:13] FRAME_B = 14'b11_11_10_11_00_00_00;
    localparam logic [0:13] FRAME_Z = 14'b00_00_00_00_00_00_00;
    localparam logic [0:13] FRAME_P = 14'b11_11_01_00_00_00_00;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               restart;
    logic               enable;
    logic               start;
    logic [0:K*L-1]     message;
    logic               load;
    logic [M-K-1:0]     state_address;
    logic [K-1:0]       input_address;
    logic [M-K-1:0]     next_state_data;
    logic [0:N-1]       output_data;
    logic [0:N-1]       encoded;
    logic               encoded_valid;
    logic [0:N*L-1]     encoded_frame;
    logic [M-K-1:0]     final_state;
    logic               busy;
    logic               done;

    int checks   = 0;
    int failures = 0;

    convolutional_encoder #(.N(N), .K(K), .M(M), .L(L)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .restart         (restart),
        .enable          (enable),
        .start           (start),
        .message         (message),
        .load            (load),
        .state_address   (state_address),
        .input_address   (input_address),
        .next_state_data (next_state_data),
        .output_data     (output_data),
        .encoded         (encoded),
        .encoded_valid   (encoded_valid),
        .encoded_frame   (encoded_frame),
        .final_state     (final_state),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Table contents derived from generators g0=1111, g1=1101;
    // state bits {u[t-1], u[t-2], u[t-3]}.
    task automatic load_tables();
        logic [2:0] s;
        logic       u;
        for (int i = 0; i < 16; i++) begin
            s = i[3:1];
            u = i[0];
            load            = 1'b1;
            state_address   = s;
            input_address   = u;
            output_data[0]  = u ^ s[2] ^ s[1] ^ s[0];
            output_data[1]  = u ^ s[2] ^ s[0];
            next_state_data = {u, s[2], s[1]};
            tick();
        end
        load = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic step_check(input string tag, input int j, input logic [0:13] ef);
        logic [0:1] sl;
        sl = ef[2*j +: 2];
        tick();
        check($sformatf("%s_valid%0d", tag, j), {31'd0, encoded_valid}, 32'd1);
        check($sformatf("%s_slice%0d", tag, j), {30'd0, encoded}, {30'd0, sl});
    endtask

    task automatic end_check(input string tag, input logic [0:13] ef);
        check({tag, "_done"},  {31'd0, done}, 32'd1);
        check({tag, "_frame"}, {18'd0, encoded_frame}, {18'd0, ef});
        check({tag, "_final"}, {29'd0, final_state}, 32'd0);
        tick();
        check({tag, "_valid_after"}, {31'd0, encoded_valid}, 32'd0);
        check({tag, "_done_hold"},   {31'd0, done}, 32'd1);
        check({tag, "_busy_after"},  {31'd0, busy}, 32'd0);
    endtask

    task automatic run_frame(input string tag, input logic [0:6] msg, input logic [0:13] ef);
        start   = 1'b1;
        enable  = 1'b1;
        message = msg;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int j = 0; j < L; j++) begin
            step_check(tag, j, ef);
        end
        end_check(tag, ef);
    endtask

    initial begin
        reset_n         = 1'b0;
        restart         = 1'b0;
        enable          = 1'b0;
        start           = 1'b0;
        message         = '0;
        load            = 1'b0;
        state_address   = '0;
        input_address   = '0;
        next_state_data = '0;
        output_data     = '0;

        // Reset state
        #12;
        check("rst_encoded", {30'd0, encoded}, 32'd0);
        check("rst_valid",   {31'd0, encoded_valid}, 32'd0);
        check("rst_frame",   {18'd0, encoded_frame}, 32'd0);
        check("rst_final",   {29'd0, final_state}, 32'd0);
        check("rst_busy",    {31'd0, busy}, 32'd0);
        check("rst_done",    {31'd0, done}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Scenario 1: basic frame
        load_tables();
        run_frame("a1", MSG_A, FRAME_A);

        // Scenario 2: impulse and all-zero frames after restart
        do_restart();
        check("rs_done",  {31'd0, done}, 32'd0);
        check("rs_busy",  {31'd0, busy}, 32'd0);
        check("rs_frame_hold", {18'd0, encoded_frame}, {18'd0, FRAME_A});
        run_frame("b1", MSG_B, FRAME_B);
        do_restart();
        run_frame("z1", MSG_Z, FRAME_Z);

        // IDLE corner cases: start without enable, load beats start
        do_restart();
        start   = 1'b1;
        enable  = 1'b0;
        message = MSG_A;
        tick();
        check("idle_noenable_busy", {31'd0, busy}, 32'd0);
        enable          = 1'b1;
        load            = 1'b1;
        state_address   = 3'd0;
        input_address   = 1'b0;
        next_state_data = 3'd0;
        output_data     = 2'b00;
        tick();
        check("idle_load_wins_busy", {31'd0, busy}, 32'd0);
        load  = 1'b0;
        start = 1'b0;

        // Scenario 3: pause after two slices; message input changes mid-frame
        start   = 1'b1;
        enable  = 1'b1;
        message = MSG_A;
        tick();
        start = 1'b0;
        step_check("p1", 0, FRAME_A);
        step_check("p1", 1, FRAME_A);
        enable  = 1'b0;
        message = MSG_Z;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("pause_valid%0d", c),   {31'd0, encoded_valid}, 32'd0);
            check($sformatf("pause_encoded%0d", c), {30'd0, encoded}, 32'd3);
            check($sformatf("pause_busy%0d", c),    {31'd0, busy}, 32'd1);
        end
        enable = 1'b1;
        for (int j = 2; j < L; j++) begin
            step_check("p1", j, FRAME_A);
        end
        end_check("p1", FRAME_A);

        // Scenario 4: restart after three slices, then a clean new frame
        do_restart();
        start   = 1'b1;
        message = MSG_A;
        tick();
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step_check("r1", j, FRAME_A);
        end
        do_restart();
        check("r1_busy",  {31'd0, busy}, 32'd0);
        check("r1_valid", {31'd0, encoded_valid}, 32'd0);
        check("r1_done",  {31'd0, done}, 32'd0);
        check("r1_frame_partial", {18'd0, encoded_frame}, {18'd0, FRAME_P});
        run_frame("r2", MSG_B, FRAME_B);

        // Scenario 5: load and start in RUN, start in DONE, all ignored
        do_restart();
        start   = 1'b1;
        message = MSG_A;
        tick();
        start = 1'b0;
        step_check("l1", 0, FRAME_A);
        load            = 1'b1;
        state_address   = 3'd3;
        input_address   = 1'b0;
        next_state_data = 3'd7;
        output_data     = 2'b10;
        start           = 1'b1;
        message         = MSG_B;
        step_check("l1", 1, FRAME_A);
        load  = 1'b0;
        start = 1'b0;
        for (int j = 2; j < L; j++) begin
            step_check("l1", j, FRAME_A);
        end
        check("l1_done",  {31'd0, done}, 32'd1);
        check("l1_frame", {18'd0, encoded_frame}, {18'd0, FRAME_A});
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("done_start_done",  {31'd0, done}, 32'd1);
        check("done_start_busy",  {31'd0, busy}, 32'd0);
        check("done_start_valid", {31'd0, encoded_valid}, 32'd0);
        check("done_start_frame", {18'd0, encoded_frame}, {18'd0, FRAME_A});

        // Scenario 6: async reset mid-frame, tables lost, then reload
        do_restart();
        start   = 1'b1;
        message = MSG_A;
        tick();
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step_check("x1", j, FRAME_A);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_encoded", {30'd0, encoded}, 32'd0);
        check("arst_valid",   {31'd0, encoded_valid}, 32'd0);
        check("arst_frame",   {18'd0, encoded_frame}, 32'd0);
        check("arst_final",   {29'd0, final_state}, 32'd0);
        check("arst_busy",    {31'd0, busy}, 32'd0);
        check("arst_done",    {31'd0, done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_frame("x2", MSG_A, FRAME_Z);
        do_restart();
        load_tables();
        run_frame("x3", MSG_A, FRAME_A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/convolutional_encoder.md
Name: convolutional_encoder

Overview:
- Table-driven convolutional encoder; the transmit-side counterpart of the Viterbi decoder.
- Loads the same Next State and Output tables through the same load interface as the decoder.
- Accepts one k*L-bit message frame and emits one n-bit encoded slice per enabled cycle for L cycles.
- Also assembles the full n*L-bit frame for direct comparison with, or feeding to, the decoder.

Parameters:
- n, 2, encoded bits emitted per step.
- k, 1, message bits consumed per step.
- m, 4, generator size; the state register is m-k bits wide.
- L, 7, steps per frame; the state starts at 0 for every frame.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset (already decided).
- restart  in  1  synchronous; abandon the current frame and return to IDLE; tables are retained.
- enable  in  1  step qualifier; 0 pauses encoding.
- start  in  1  frame start request, sampled in IDLE only.
- message  in  k*L  frame to encode, [0:k*L-1]; slice j = message[k*j +: k].
- load  in  1  table write strobe.
- state_address  in  m-k  table row.
- input_address  in  k  table column.
- next_state_data  in  m-k  Next State Table write data.
- output_data  in  n  Output Table write data.
- encoded  out  n  current encoded slice, [0:n-1].
- encoded_valid  out  1  high for exactly one cycle per emitted slice.
- encoded_frame  out  n*L  accumulated frame; slice j at [n*j +: n].
- final_state  out  m-k  encoder state after the last step.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Tables: two register arrays of 2^(m-k) x 2^k entries.
- Writes take effect at the rising edge when load=1 and the FSM is in IDLE. Load is ignored in RUN and DONE.
- reset_n=0 clears both tables, FSM->IDLE, step counter=0, state register=0, and every output to 0.
- FSM IDLE:
  - start=1 and enable=1 at an edge: latch message, clear state register, counter and encoded_frame; go to RUN.
  - load and start together: load wins; start is ignored.
- FSM RUN: at each edge with enable=1, for u = msg[k*cnt +: k]:
  - encoded <= Out[state][u]
  - encoded_frame[n*cnt +: n] <= Out[state][u]
  - state <= NS[state][u]
  - encoded_valid <= 1, cnt <= cnt+1
- RUN exit: the edge that emits step L-1 also moves the FSM to DONE and sets final_state to the post-step state.
- Latency: slice j is visible after edge j+1 counted from the start edge. done rises with the last valid slice, L cycles after start when there are no pauses.
- Pause: an edge with enable=0 in RUN clears encoded_valid. encoded, the counter and the state register hold.
- FSM DONE: holds encoded_frame, final_state, done=1 and encoded_valid=0. start is ignored; only restart or reset_n leaves DONE.
- restart=1 at an edge, from any state: FSM->IDLE, counter=0, state register=0, encoded_valid=0, done=0, busy=0. encoded_frame and final_state hold. restart has priority over start and over stepping.
- start during RUN is ignored. The latched message is immune to changes on the message input mid-frame.
- Asynchronous reset_n mid-frame aborts immediately; the tables are lost and must be reloaded.
- Counter width: clog2(L)+1 bits; it never wraps because RUN exits at L-1.

Test Plan:
- Reset, load the 16-entry (m=4) rate-1/2 tables, message=1011_000 with enable held -> encoded sequence 11,11,01,11,01,01,11 on 7 consecutive valid cycles; encoded_frame=11_11_01_11_01_01_11; final_state=000; done after the 7th slice.
- restart, then message=1000_000 -> encoded_frame=11_11_10_11_00_00_00, final_state=000. Next, restart, then message=0000_000 -> all-zero frame.
- message=1011_000 with enable low for 3 cycles after slice 2 -> encoded holds 11 and valid is low during the pause; final frame is unchanged from the first scenario.
- restart asserted after slice 3, then a new start with 1000_000 -> clean frame as in the second scenario; no carry-over of state or counter.
- load asserted during RUN with a corrupting entry -> ignored; frame still matches the first scenario. start pulsed in RUN and in DONE -> ignored.
- reset_n low mid-frame -> all outputs 0 immediately; a start without reloading yields an all-zero frame. Reload the tables and rerun -> frame matches the first scenario.
